// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART line-rate constants and receiver state encoding
package uart_pkg;

    localparam int UART_FREQ = 12000000;
    localparam int UART_BAUD = 9600;

    // Clocks per line bit for a given system clock and baud rate.
    function automatic int uart_cpb(input int freq, input int baud);
        return freq / baud;
    endfunction

    // Clocks from start-edge detection to the middle of the start bit.
    function automatic int uart_half(input int freq, input int baud);
        return (freq / baud) / 2;
    endfunction

    localparam int UART_CPB  = uart_cpb(UART_FREQ, UART_BAUD);
    localparam int UART_HALF = uart_half(UART_FREQ, UART_BAUD);

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s1_d;
    logic s2_q;
    logic s2_d;

    // Next-state of the two-stage shift toward the clock domain.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchronizer flops; reset to the line's idle level so no false edge appears.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - oversampling 8N1 UART receiver with valid/ready byte output
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int FREQ = UART_FREQ,
    parameter int BAUD = UART_BAUD,
    parameter int CW   = 11
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CPB  = uart_cpb(FREQ, BAUD);
    localparam int HALF = uart_half(FREQ, BAUD);

    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);

    localparam logic [2:0] ST_IDLE  = RX_IDLE;
    localparam logic [2:0] ST_START = RX_START;
    localparam logic [2:0] ST_DATA  = RX_DATA;
    localparam logic [2:0] ST_STOP  = RX_STOP;
    localparam logic [2:0] ST_BREAK = RX_BREAK;

    logic          rx_s;

    logic [2:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [2:0]    bit_idx_q,   bit_idx_d;
    logic [7:0]    shift_q,     shift_d;
    logic [7:0]    data_q,      data_d;
    logic          valid_q,     valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q,   overrun_d;
    logic          deliver;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (rx_in),
        .q    (rx_s)
    );

    // Framing FSM plus the single-entry holding register and its handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // Line back high at mid-start means a glitch, not a frame.
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Leave at mid-stop so a back-to-back start edge is seen.
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    // State, datapath and output registers; reset drops any frame or pending byte.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver front end: oversamples the asynchronous serial line `rx_in` at the system clock, frames 8N1 characters and presents each byte on a valid/ready output.
- Sits directly upstream of the team's byte-buffering/retransmit transmitter and feeds it parallel bytes, replacing ad-hoc serial shifting.
- Reports framing errors and overruns as single-cycle pulses.

Parameters:
- FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- CPB, FREQ/BAUD (1250), clocks per bit. Must be >= 4.
- HALF, CPB/2 (625), clocks from start-edge detection to mid-start-bit.
- CW, 11, counter width. Must satisfy 2^CW > CPB.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset: synchronous, active-low.
- rx_in  in  1  asynchronous serial line; idle high.
- rx_data  out  8  received byte, LSB first on the line; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid&&rx_ready at a rising edge.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a byte is dropped because the holding register is full.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- **Reset** (nrst=0 at a rising edge):
  - Synchronizer flops = 1, FSM = IDLE, counters = 0.
  - rx_data = 0x00; rx_valid, frame_err, overrun, busy = 0.
  - Reset mid-frame aborts the frame silently and discards any pending byte.
- **Synchronizer:** two flops; rx_s is the second flop. All FSM decisions use rx_s only.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** at edge E where rx_s=0, go to START with cnt=0.
- **START:**
  - cnt counts 0..HALF-1, so START lasts HALF cycles.
  - At cnt=HALF-1: if rx_s=0, go to DATA with cnt=0, bit index=0. Otherwise return to IDLE (glitch rejected, no flags).
- **DATA:**
  - cnt counts 0..CPB-1.
  - At cnt=CPB-1: shift rx_s into shift[7] (right shift, LSB first), increment bit index, set cnt=0.
  - After the 8th sample, go to STOP.
- **STOP:** at cnt=CPB-1, sample rx_s.
  - rx_s=1: deliver the byte (see handshake), go to IDLE.
  - rx_s=0: pulse frame_err, discard the byte, go to BREAK.
- **BREAK:** wait for rx_s=1, then go to IDLE. A line held low produces no further frames.
- **Timing:**
  - Stop bit sampled at E+HALF+9*CPB; rx_valid=1 from cycle E+HALF+9*CPB+1.
  - With defaults, E+11876.
  - Return to IDLE at mid-stop-bit, so a back-to-back start edge is caught.
- **Handshake and holding register:**
  - Delivery with rx_valid=0: rx_data<=shift, rx_valid<=1.
  - Delivery with rx_valid=1 and rx_ready=1 in the same cycle: old byte is consumed, new byte is loaded, rx_valid stays 1.
  - Delivery with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun pulses 1 cycle.
  - Acceptance with no delivery: rx_valid<=0; rx_data holds its last value.
  - rx_ready while rx_valid=0 is ignored.
- **Pulse alignment:** frame_err and overrun are never high for more than one cycle. They rise on the cycle following the stop sample.
- **busy:** combinational decode of state != IDLE.

Decomposition:
- **Package uart_pkg:**
  - FREQ and BAUD defaults.
  - CPB and HALF derivation.
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - Shared with the transmitter.
- **Sub-module uart_sync2:** 2-flop synchronizer with reset value parameter (1 here), reused for other asynchronous inputs.

Test Plan:
1. **Single byte:** drive 0x53 at 1250 clk/bit, rx_ready=1 → rx_data=0x53, rx_valid high exactly 1 cycle, first at E+11876; frame_err=overrun=0.
2. **Back-to-back bytes:** stream 0x53,0x6E,0x61,0x70 with no idle gap, rx_ready=1 → four transfers in order; busy drops only briefly between frames.
3. **Glitch rejection:** 300-cycle low pulse on rx_in → no rx_valid, no flags; busy high ~HALF cycles then low.
4. **Framing error:** 0xA5 with stop bit low, line held low 5000 cycles, then a valid 0x3C → frame_err 1-cycle pulse, no valid for 0xA5; FSM in BREAK until line high; then rx_data=0x3C.
5. **Overrun:** rx_ready=0, send 0x11 then 0x22 → rx_valid=1 with 0x11, overrun pulse at the 0x22 stop sample, rx_data stays 0x11. Raising rx_ready then drops rx_valid.
6. **Reset mid-frame:** nrst=0 for 1 cycle mid-bit-4 → all outputs reset values; a following 0x7E frame is received correctly.
